// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC and the instruction memory and drives the IF/ID register.
// The memory is loaded through the program port while the stage is idle, then fetched one word per cycle.
module instruction_fetch #(
  parameter int SIZE      = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  input  logic              i_stall,
  input  logic              i_jump_brch,
  input  logic [SIZE-1:0]   i_jump_target,
  input  logic              i_flush,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [SIZE-1:0]   i_prog_data,
  output logic [SIZE-1:0]   o_instruction,
  output logic [SIZE-1:0]   o_pc,
  output logic              o_valid,
  output logic              o_halt,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    HALTED = 2'b10
  } state_e;

  localparam logic [SIZE-1:0] NOP     = '0;
  localparam logic [5:0]      HALT_OP = 6'b111111;

  state_e          state_q, state_d;
  logic [SIZE-1:0] pc_q, pc_d;
  logic [SIZE-1:0] instr_q, instr_d;
  logic [SIZE-1:0] ifid_pc_q, ifid_pc_d;
  logic            valid_q, valid_d;
  logic            halt_q, halt_d;

  logic [SIZE-1:0] mem_q [MEM_DEPTH];
  logic [SIZE-1:0] fetch_word;
  logic            fetch_is_halt;
  logic [SIZE-1:0] pc_inc;

  // Program memory survives reset so a loaded program can be re-run after rst.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && i_prog_we) begin
      mem_q[i_prog_addr] <= i_prog_data;
    end
  end

  assign fetch_word    = mem_q[pc_q[ADDR_W-1:0]];
  assign fetch_is_halt = (fetch_word[SIZE-1 -: 6] == HALT_OP);
  assign pc_inc        = pc_q + SIZE'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      instr_q   <= NOP;
      ifid_pc_q <= '0;
      valid_q   <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      ifid_pc_q <= ifid_pc_d;
      valid_q   <= valid_d;
      halt_q    <= halt_d;
    end
  end

  // Stall and run-low win over redirects because decode keeps presenting a held request.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    ifid_pc_d = ifid_pc_q;
    valid_d   = valid_q;
    halt_d    = halt_q;

    unique case (state_q)
      IDLE: begin
        pc_d      = '0;
        instr_d   = NOP;
        ifid_pc_d = '0;
        valid_d   = 1'b0;
        halt_d    = 1'b0;
        if (i_run) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (i_stall || !i_run) begin
          state_d = FETCH;
        end else if (i_jump_brch) begin
          pc_d    = i_jump_target;
          instr_d = NOP;
          valid_d = 1'b0;
        end else if (i_flush) begin
          pc_d    = pc_inc;
          instr_d = NOP;
          valid_d = 1'b0;
        end else begin
          instr_d   = fetch_word;
          ifid_pc_d = pc_q;
          valid_d   = 1'b1;
          if (fetch_is_halt) begin
            halt_d  = 1'b1;
            state_d = HALTED;
          end else begin
            pc_d = pc_inc;
          end
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_instruction = instr_q;
  assign o_pc          = ifid_pc_q;
  assign o_valid       = valid_q;
  assign o_halt        = halt_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch stage.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic        i_run;
  logic        i_stall;
  logic        i_jump_brch;
  logic [31:0] i_jump_target;
  logic        i_flush;
  logic        i_prog_we;
  logic [7:0]  i_prog_addr;
  logic [31:0] i_prog_data;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic        o_valid;
  logic        o_halt;
  logic [1:0]  o_state;

  int total;
  int bad;

  // Behavioural model: 0 idle, 1 fetching, 2 halted
  logic [31:0] m_mem [256];
  int          m_state;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_opc;
  logic        m_valid;
  logic        m_halt;

  instruction_fetch #(.SIZE(32), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .i_run(i_run), .i_stall(i_stall),
    .i_jump_brch(i_jump_brch), .i_jump_target(i_jump_target), .i_flush(i_flush),
    .i_prog_we(i_prog_we), .i_prog_addr(i_prog_addr), .i_prog_data(i_prog_data),
    .o_instruction(o_instruction), .o_pc(o_pc), .o_valid(o_valid),
    .o_halt(o_halt), .o_state(o_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_state = 0;
    m_pc    = 0;
    m_instr = 0;
    m_opc   = 0;
    m_valid = 0;
    m_halt  = 0;
  endtask

  task automatic model_edge();
    logic [31:0] w;
    if (!rst) begin
      model_reset();
    end else if (m_state == 0) begin
      if (i_prog_we) m_mem[i_prog_addr] = i_prog_data;
      if (i_run) m_state = 1;
    end else if (m_state == 1) begin
      if (i_stall || !i_run) begin
        // hold
      end else if (i_jump_brch) begin
        m_pc = i_jump_target; m_instr = 0; m_valid = 0;
      end else if (i_flush) begin
        m_pc = m_pc + 1; m_instr = 0; m_valid = 0;
      end else begin
        w = m_mem[m_pc % 256];
        m_instr = w; m_opc = m_pc; m_valid = 1;
        if (w[31:26] == 6'h3f) begin
          m_halt = 1; m_state = 2;
        end else begin
          m_pc = m_pc + 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    i_run = 0; i_stall = 0; i_jump_brch = 0; i_jump_target = 0;
    i_flush = 0; i_prog_we = 0; i_prog_addr = 0; i_prog_data = 0;
  endtask

  // Pulses rst low between clock edges; called just after an edge.
  task automatic pulse_reset();
    idle_inputs();
    #2;
    rst = 0;
    model_reset();
    #2;
    rst = 1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3f) w[31] = 1'b0;
    return w;
  endfunction

  task automatic restart_fetch(input int fetches);
    pulse_reset();
    i_run = 1;
    step();
    for (int k = 0; k < fetches; k++) step();
  endtask

  task automatic test_reset();
    logic [31:0] prog [4];
    prog = '{32'h2001_0005, 32'h2002_0003, 32'h0000_0000, 32'hFC00_0000};
    idle_inputs();
    rst = 0;
    model_reset();
    #13;
    if (o_pc !== 0 || o_instruction !== 0 || o_valid !== 0 || o_halt !== 0 || o_state !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_outputs actual pc=%h ins=%h v=%b h=%b st=%b required all zero", o_pc, o_instruction, o_valid, o_halt, o_state);
    end
    total++;
    rst = 1;
    for (int a = 0; a < 256; a++) begin
      i_prog_we = 1;
      i_prog_addr = 8'(a);
      i_prog_data = (a < 4) ? prog[a] : rand_word();
      step();
    end
    i_prog_we = 0;
    if (o_state !== 2'b00 || o_valid !== 0) begin
      bad++;
      $display("[TB] FAIL idle_after_load actual st=%b v=%b required st=00 v=0", o_state, o_valid);
    end
    total++;
  endtask

  task automatic test_load_halt();
    logic [31:0] exp_ins [4];
    exp_ins = '{32'h2001_0005, 32'h2002_0003, 32'h0000_0000, 32'hFC00_0000};
    i_run = 1;
    step();
    if (o_state !== 2'b01 || o_valid !== 0) begin
      bad++;
      $display("[TB] FAIL idle_to_fetch actual st=%b v=%b required st=01 v=0", o_state, o_valid);
    end
    total++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_pc !== 32'(i) || o_instruction !== exp_ins[i] || o_valid !== 1 || o_halt !== (i == 3)) begin
        bad++;
        $display("[TB] FAIL fetch_seq%0d actual pc=%h ins=%h v=%b h=%b required pc=%h ins=%h v=1 h=%b",
                 i, o_pc, o_instruction, o_valid, o_halt, 32'(i), exp_ins[i], (i == 3));
      end
      total++;
    end
    for (int c = 0; c < 10; c++) begin
      i_stall = 1'($urandom); i_jump_brch = 1'($urandom); i_jump_target = 32'd40;
      i_flush = 1'($urandom); i_prog_we = 1; i_prog_addr = 0; i_prog_data = 32'hFFFF_FFFF;
      step();
      if (o_pc !== 3 || o_instruction !== 32'hFC00_0000 || o_valid !== 1 || o_halt !== 1 || o_state !== 2'b10) begin
        bad++;
        $display("[TB] FAIL halted_frozen%0d actual pc=%h ins=%h v=%b h=%b st=%b required pc=3 ins=fc000000 v=1 h=1 st=10",
                 c, o_pc, o_instruction, o_valid, o_halt, o_state);
      end
      total++;
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    pulse_reset();
    i_prog_we = 1; i_prog_addr = 3; i_prog_data = 32'h2003_0001;
    step();
    i_prog_we = 0;
    i_run = 1;
    step();
    step();
    if (o_pc !== 0 || o_instruction !== 32'h2001_0005) begin
      bad++;
      $display("[TB] FAIL rerun_word0 actual pc=%h ins=%h required pc=0 ins=20010005", o_pc, o_instruction);
    end
    total++;
    step();
    i_stall = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (o_pc !== 1 || o_instruction !== 32'h2002_0003 || o_valid !== 1) begin
        bad++;
        $display("[TB] FAIL stall_hold%0d actual pc=%h ins=%h v=%b required pc=1 ins=20020003 v=1", c, o_pc, o_instruction, o_valid);
      end
      total++;
    end
    i_stall = 0;
    step();
    if (o_pc !== 2 || o_instruction !== 32'h0000_0000 || o_valid !== 1) begin
      bad++;
      $display("[TB] FAIL stall_release actual pc=%h ins=%h v=%b required pc=2 ins=0 v=1", o_pc, o_instruction, o_valid);
    end
    total++;
  endtask

  task automatic test_jump();
    restart_fetch(2);
    i_jump_brch = 1; i_jump_target = 32'd8;
    step();
    if (o_valid !== 0 || o_instruction !== 0) begin
      bad++;
      $display("[TB] FAIL jump_bubble actual v=%b ins=%h required v=0 ins=0", o_valid, o_instruction);
    end
    total++;
    i_jump_brch = 0;
    step();
    if (o_pc !== 8 || o_instruction !== m_mem[8] || o_valid !== 1) begin
      bad++;
      $display("[TB] FAIL jump_target actual pc=%h ins=%h v=%b required pc=8 ins=%h v=1", o_pc, o_instruction, o_valid, m_mem[8]);
    end
    total++;
  endtask

  task automatic test_stall_jump();
    i_stall = 1; i_jump_brch = 1; i_jump_target = 32'd20;
    for (int c = 0; c < 2; c++) begin
      step();
      if (o_pc !== 8 || o_instruction !== m_mem[8] || o_valid !== 1) begin
        bad++;
        $display("[TB] FAIL stall_jump_hold%0d actual pc=%h ins=%h v=%b required pc=8 ins=%h v=1", c, o_pc, o_instruction, o_valid, m_mem[8]);
      end
      total++;
    end
    i_stall = 0;
    step();
    i_jump_brch = 0;
    step();
    if (o_pc !== 20 || o_instruction !== m_mem[20] || o_valid !== 1) begin
      bad++;
      $display("[TB] FAIL stall_jump_redirect actual pc=%h ins=%h v=%b required pc=14 ins=%h v=1", o_pc, o_instruction, o_valid, m_mem[20]);
    end
    total++;
  endtask

  task automatic test_flush_lockout();
    logic [31:0] orig5;
    orig5 = m_mem[5];
    restart_fetch(4);
    i_flush = 1; i_prog_we = 1; i_prog_addr = 5; i_prog_data = ~orig5;
    step();
    if (o_valid !== 0 || o_instruction !== 0) begin
      bad++;
      $display("[TB] FAIL flush_bubble actual v=%b ins=%h required v=0 ins=0", o_valid, o_instruction);
    end
    total++;
    i_flush = 0; i_prog_we = 0;
    step();
    if (o_pc !== 5 || o_instruction !== orig5 || o_valid !== 1) begin
      bad++;
      $display("[TB] FAIL flush_advance_lockout actual pc=%h ins=%h v=%b required pc=5 ins=%h v=1", o_pc, o_instruction, o_valid, orig5);
    end
    total++;
  endtask

  task automatic test_wrap_reset();
    i_jump_brch = 1; i_jump_target = 32'd255;
    step();
    i_jump_brch = 0;
    step();
    if (o_pc !== 255 || o_instruction !== m_mem[255]) begin
      bad++;
      $display("[TB] FAIL wrap_255 actual pc=%h ins=%h required pc=ff ins=%h", o_pc, o_instruction, m_mem[255]);
    end
    total++;
    step();
    if (o_pc !== 32'd256 || o_instruction !== 32'h2001_0005) begin
      bad++;
      $display("[TB] FAIL wrap_256 actual pc=%h ins=%h required pc=100 ins=20010005", o_pc, o_instruction);
    end
    total++;
    #2;
    rst = 0;
    model_reset();
    #1;
    if (o_pc !== 0 || o_instruction !== 0 || o_valid !== 0 || o_halt !== 0 || o_state !== 2'b00) begin
      bad++;
      $display("[TB] FAIL async_reset actual pc=%h ins=%h v=%b h=%b st=%b required all zero", o_pc, o_instruction, o_valid, o_halt, o_state);
    end
    total++;
    #1;
    rst = 1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 59) == 0) pulse_reset();
      i_run         = ($urandom_range(0, 9) != 0) && (m_state != 0 || $urandom_range(0, 3) == 0);
      i_stall       = ($urandom_range(0, 4) == 0);
      i_jump_brch   = ($urandom_range(0, 7) == 0);
      i_jump_target = 32'($urandom_range(0, 300));
      i_flush       = ($urandom_range(0, 7) == 0);
      i_prog_we     = ($urandom_range(0, 1) == 0);
      i_prog_addr   = 8'($urandom);
      i_prog_data   = ($urandom_range(0, 15) == 0) ? 32'hFC00_0000 : rand_word();
      step();
      if (o_instruction !== m_instr || o_valid !== m_valid) begin
        bad++;
        $display("[TB] FAIL rand_ifid%0d actual ins=%h v=%b required ins=%h v=%b", c, o_instruction, o_valid, m_instr, m_valid);
      end
      total++;
      if (m_valid && o_pc !== m_opc) begin
        bad++;
        $display("[TB] FAIL rand_pc%0d actual pc=%h required pc=%h", c, o_pc, m_opc);
      end
      total++;
      if (o_halt !== m_halt || o_state !== 2'(m_state)) begin
        bad++;
        $display("[TB] FAIL rand_ctrl%0d actual h=%b st=%b required h=%b st=%0d", c, o_halt, o_state, m_halt, m_state);
      end
      total++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_halt();
    test_stall();
    test_jump();
    test_stall_jump();
    test_flush_lockout();
    test_wrap_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
